// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath multiplier.
//   mult_state_t : multiplier FSM states (IDLE, RUN, DONE)
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : iteration counter width for MULT_WIDTH
//   MULT_PROD_W  : product width for MULT_WIDTH
package mips_pkg;

    localparam int unsigned MULT_WIDTH  = 32;
    localparam int unsigned MULT_CNT_W  = $clog2(MULT_WIDTH + 1);
    localparam int unsigned MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mips_mult_step.sv
// One shift-add multiply iteration.
// Conditionally adds the multiplicand into the upper half of the partial product,
// keeping the carry, then shifts {carry, acc} right by one.
//   acc_i   in  2*WIDTH  current partial product
//   mcand_i in  WIDTH    multiplicand magnitude
//   lsb_i   in  1        current multiplier LSB (add enable)
//   acc_o   out 2*WIDTH  next partial product
module mips_mult_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               lsb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic           unused_acc_lsb;

    always_comb begin
        sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (lsb_i ? {1'b0, mcand_i} : '0);
        // The carry becomes the new MSB; acc_i[0] falls off the bottom.
        acc_o = {sum, acc_i[WIDTH-1:1]};
    end

    assign unused_acc_lsb = acc_i[0];

endmodule

// File: rtl/mips_mult_unit.sv
// Multi-cycle shift-add multiplier for MULT/MULTU, result into HI/LO.
// Operands are converted to magnitudes on accept; the sign is reapplied when the
// product is written to hi/lo at DONE entry.
//   clk       in  1      clock
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      request a multiply (sampled only in IDLE)
//   signed_op in  1      1 = MULT, 0 = MULTU
//   op_a      in  WIDTH  multiplicand (rs)
//   op_b      in  WIDTH  multiplier (rt)
//   busy      out 1      high in RUN and DONE
//   done      out 1      one-cycle pulse, hi/lo hold the new product
//   hi        out WIDTH  product upper half
//   lo        out WIDTH  product lower half
// Build option MIPS_MULT_EARLY_EXIT_EN: leave RUN once the remaining multiplier
// is zero, realigning the partial product by the leftover iteration count.
module mips_mult_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    mult_state_t       state_q, state_d;
    logic [PROD_W-1:0] acc_q, acc_next, prod_abs, prod_fin;
    logic [WIDTH-1:0]  mcand_q, mult_q, hi_q, lo_q, mag_a, mag_b;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, run_exit;
`ifdef MIPS_MULT_EARLY_EXIT_EN
    logic              mz_q;
`endif

    mips_mult_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (mult_q[0]),
        .acc_o   (acc_next)
    );

    always_comb begin
        mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
`ifdef MIPS_MULT_EARLY_EXIT_EN
        // mz_q is the zero test of the multiplier registered one iteration late,
        // keeping the wide compare off the exit path; the extra iteration only
        // shifts, and the realignment by cnt_q absorbs it.
        run_exit = (cnt_q == '0) || mz_q;
        prod_abs = acc_q >> cnt_q;
`else
        run_exit = (cnt_q == '0);
        prod_abs = acc_q;
`endif
        prod_fin = neg_q ? -prod_abs : prod_abs;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_exit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MIPS_MULT_EARLY_EXIT_EN
            mz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= mag_a;
                        mult_q  <= mag_b;
                        neg_q   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
`ifdef MIPS_MULT_EARLY_EXIT_EN
                        mz_q    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        hi_q <= prod_fin[PROD_W-1:WIDTH];
                        lo_q <= prod_fin[WIDTH-1:0];
                    end else begin
                        acc_q  <= acc_next;
                        mult_q <= mult_q >> 1;
                        cnt_q  <= cnt_q - CNT_W'(1);
`ifdef MIPS_MULT_EARLY_EXIT_EN
                        mz_q   <= (mult_q == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mult_unit.sv
// Directed bench for mips_mult_unit with hand-computed products.
module tb_mips_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, signed_op;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_prod = '0;

    always #5 clk = ~clk;

    mips_mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected edges from accept to done visible.
    function automatic int lat_of(input logic sgn, input logic [31:0] b);
`ifdef MIPS_MULT_EARLY_EXIT_EN
        logic [31:0] m;
        int          idx;
        m   = (sgn && b[31]) ? -b : b;
        idx = -1;
        for (int i = 0; i < 32; i++) if (m[i]) idx = i;
        if (idx < 0) return 2;
        return (idx + 3 > 33) ? 33 : idx + 3;
`else
        return 33;
`endif
    endfunction

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while ((busy || done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("launch_idle", 64'(busy), 64'(0));
        signed_op = sgn;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int poke, input logic [63:0] prev, output int edges);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == poke) begin
                chk("poke_busy", 64'(busy), 64'(1));
                chk("poke_hold", {hi, lo}, prev);
                signed_op = 1'b0;
                op_a      = 32'd7;
                op_b      = 32'd9;
                start     = 1'b1;
                @(posedge clk);
                edges++;
                #1 start = 1'b0;
                chk("poke_busy2", 64'(busy), 64'(1));
            end
            if (done) break;
        end
    endtask

    task automatic do_mult(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int poke);
        int e;
        launch(sgn, a, b);
        wait_done(poke, last_prod, e);
        chk({tag, "_lat"}, 64'(e), 64'(lat_of(sgn, b)));
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 64'(done), 64'(0));
        last_prod = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n_done;
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        do_mult("u3x5",   1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F, 0);
        do_mult("uffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        do_mult("sm1x1",  1'b1, 32'hFFFF_FFFF, 32'd1,        64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_mult("s80x80", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        do_mult("sm3x5",  1'b1, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 0);
        do_mult("s7xm6",  1'b1, 32'd7,        32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, 0);
        do_mult("u80x2",  1'b0, 32'h8000_0000, 32'd2,        64'h0000_0001_0000_0000, 0);
        do_mult("s80x2",  1'b1, 32'h8000_0000, 32'd2,        64'hFFFF_FFFF_0000_0000, 0);
        do_mult("ushift", 1'b0, 32'h1234_5678, 32'h10,       64'h0000_0001_2345_6780, 0);
        do_mult("uzero",  1'b0, 32'hDEAD_BEEF, 32'd0,        64'h0,                   0);
        // start raised mid-RUN is ignored; the original product completes.
        do_mult("poke",   1'b0, 32'h1234,     32'h8003,     64'h0000_0000_091A_369C, 10);

        // Reset in the middle of RUN aborts without a done pulse.
        launch(1'b0, 32'd2, 32'h8000_0003);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_hi", 64'(hi), 64'(0));
        chk("mrst_lo", 64'(lo), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) n_done++;
        end
        chk("mrst_no_done", 64'(n_done), 64'(0));
        last_prod = '0;

        do_mult("u2x2", 1'b0, 32'd2, 32'd2, 64'h4, 0);

        // Back-to-back: launch immediately after the previous done.
        launch(1'b0, 32'd6, 32'd7);
        wait_done(0, last_prod, e);
        chk("b2b_a_lo", 64'(lo), 64'd42);
        launch(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        wait_done(0, 64'd42, e);
        chk("b2b_b_lat", 64'(e), 64'(lat_of(1'b1, 32'hFFFF_FFFE)));
        chk("b2b_b_prod", {hi, lo}, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
